// File: rtl/reset_sequencer_if.sv
// Reset sequencer bus: raw lock and software reset in, staged resets and status out.
// master drives locked/sw_reset and observes the outputs; slave is the sequencer.
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    logic                  locked;
    logic                  sw_reset;
    logic [NUM_STAGES-1:0] stage_reset;
    logic                  running;
    logic                  led_status;

    modport master (
        output locked,
        output sw_reset,
        input  stage_reset,
        input  running,
        input  led_status
    );

    modport slave (
        input  locked,
        input  sw_reset,
        output stage_reset,
        output running,
        output led_status
    );
endinterface

// File: rtl/reset_sequencer.sv
// Power-on / lock-loss reset sequencer: filters PLL lock, holds, then releases
// NUM_STAGES reset domains in index order with a fixed gap between them.
// Ports: clk, reset (async, active-high), bus (slave): locked, sw_reset in;
// stage_reset[NUM_STAGES-1:0], running, led_status out.
// Optional: define RESET_SEQ_HEARTBEAT_EN for a heartbeat on led_status.
module reset_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int LOCK_FILTER = 8,
    parameter int HB_BITS     = 22
) (
    input  logic             clk,
    input  logic             reset,
    reset_sequencer_if.slave bus
);
    localparam int LW = $clog2(LOCK_FILTER) + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam int GW = $clog2(STAGE_GAP) + 1;

    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_FILTER - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);

    localparam logic [NUM_STAGES-1:0] ALL_ON    = {NUM_STAGES{1'b1}};
    localparam logic [NUM_STAGES-1:0] LAST_ONLY =
        NUM_STAGES'(1) << (NUM_STAGES - 1);

    if (NUM_STAGES < 1 || HOLD_CYCLES < 1 || STAGE_GAP < 1 ||
        LOCK_FILTER < 1 || HB_BITS < 1) begin : g_bad_params
        $error("reset_sequencer: all parameters must be >= 1");
    end

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        RELEASE,
        RUN
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            sync_q;
    logic [LW-1:0]         lock_cnt_q, lock_cnt_d;
    logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic [NUM_STAGES-1:0] sr_q, sr_d;
    logic                  running_q, running_d;
    logic                  lock_s;

    assign lock_s = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            state_q    <= WAIT_LOCK;
            lock_cnt_q <= '0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            sr_q       <= ALL_ON;
            running_q  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], bus.locked};
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            sr_q       <= sr_d;
            running_q  <= running_d;
        end
    end

    // Released stages form a run of zeros growing from bit 0, so every
    // release is a left shift; a higher bit can never clear before a lower one.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        sr_d       = sr_q;
        running_d  = running_q;

        unique case (state_q)
            WAIT_LOCK: begin
                sr_d      = ALL_ON;
                running_d = 1'b0;
                if (!lock_s) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    sr_d      = sr_q << 1;
                    gap_cnt_d = '0;
                    if (NUM_STAGES == 1) begin
                        state_d   = RUN;
                        running_d = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    sr_d      = sr_q << 1;
                    if (sr_q == LAST_ONLY) begin
                        state_d   = RUN;
                        running_d = 1'b1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            RUN: begin
                sr_d = '0;
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase

        // Lock loss outranks a software request: a lost PLL must re-qualify.
        if (state_q != WAIT_LOCK) begin
            if (!lock_s) begin
                state_d    = WAIT_LOCK;
                lock_cnt_d = '0;
                sr_d       = ALL_ON;
                running_d  = 1'b0;
            end else if (bus.sw_reset) begin
                state_d    = HOLD;
                hold_cnt_d = '0;
                sr_d       = ALL_ON;
                running_d  = 1'b0;
            end
        end
    end

    assign bus.stage_reset = sr_q;
    assign bus.running     = running_q;

`ifdef RESET_SEQ_HEARTBEAT_EN
    logic [HB_BITS-1:0] hb_q, hb_d;

    always_comb begin
        hb_d = '0;
        if (state_q == RUN && state_d == RUN) begin
            hb_d = hb_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hb_q <= '0;
        end else begin
            hb_q <= hb_d;
        end
    end

    assign bus.led_status = running_q & hb_q[HB_BITS-1];
`else
    assign bus.led_status = running_q;
`endif
endmodule
